mic1_exec_ctrl: RTL

Execution controller directly downstream of the button FSM. It consumes debounced run/stop/step levels and drives the MIC-1 datapath clock enable (mic1_ce). It supports free-run, single micro-step and single ISA-instruction step, where an instruction step ends on return to the Main1 microinstruction. It also keeps cycle and instruction counters and drives the step LEDs.

---
 rtl/mic1_exec_pkg.sv | 16 +
 rtl/mic1_req_edge.sv | 32 +++
 rtl/mic1_exec_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mic1_exec_pkg.sv
// Shared types and constants for the MIC-1 execution controller.
//   exec_state_t        : controller state encoding
//   MAIN1_ADDR_DEFAULT  : default control-store address of Main1
package mic1_exec_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RUN        = 3'd1,
        ST_STEP_MICRO = 3'd2,
        ST_STEP_INSTR = 3'd3,
        ST_HALTED     = 3'd4
    } exec_state_t;

    localparam logic [8:0] MAIN1_ADDR_DEFAULT = 9'h000;

endpackage

// File: rtl/mic1_req_edge.sv
// Rising-edge detector for a debounced button level.
//   clk    : system clock
//   resetn : synchronous reset, active-high
//   req    : debounced button level
//   pulse  : one-cycle pulse on the first cycle req is seen high
// During reset the previous-level register loads the live level, so a
// button held through reset yields no pulse after release.
module mic1_req_edge (
    input  logic clk,
    input  logic resetn,
    input  logic req,
    output logic pulse
);

    logic req_q;
    logic req_d;

    always_comb begin
        req_d = req;
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            req_q <= req;
        end else begin
            req_q <= req_d;
        end
    end

    assign pulse = req & ~req_q;

endmodule

// File: rtl/mic1_exec_ctrl.sv
// MIC-1 execution controller: turns RUN/STOP/STEP button levels into the
// datapath clock enable, supporting free-run, micro-step and ISA
// instruction step (ends on return to Main1), with cycle/instruction
// counters and step LEDs.
//   clk, resetn          : clock, synchronous active-high reset
//   run_req/stop_req/step_req : debounced button levels
//   step_mode            : 0 = micro-step, 1 = instruction step
//   mpc, halt            : datapath MPC and HALT indication
//   mic1_ce              : datapath clock enable
//   running/idle/halted  : state flags
//   step_done            : one-cycle pulse after a completed step
//   step_timeout         : sticky, last instruction step hit STEP_MAX
//   cycle_cnt/instr_cnt  : ce cycles / Main1 executions
//   led_run_step         : instr_cnt[3:0]
module mic1_exec_ctrl
    import mic1_exec_pkg::*;
#(
    parameter int unsigned      MPC_W      = 9,
    parameter logic [MPC_W-1:0] MAIN1_ADDR = MPC_W'(MAIN1_ADDR_DEFAULT),
    parameter int unsigned      CYC_W      = 32,
    parameter int unsigned      STEP_MAX   = 64
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run_req,
    input  logic             stop_req,
    input  logic             step_req,
    input  logic             step_mode,
    input  logic [MPC_W-1:0] mpc,
    input  logic             halt,
    output logic             mic1_ce,
    output logic             running,
    output logic             idle,
    output logic             halted,
    output logic             step_done,
    output logic             step_timeout,
    output logic [CYC_W-1:0] cycle_cnt,
    output logic [15:0]      instr_cnt,
    output logic [3:0]       led_run_step
);

    localparam int unsigned SC_W = $clog2(STEP_MAX + 1);

    logic run_pulse;
    logic stop_pulse;
    logic step_pulse;

    mic1_req_edge u_run_edge  (.clk(clk), .resetn(resetn), .req(run_req),  .pulse(run_pulse));
    mic1_req_edge u_stop_edge (.clk(clk), .resetn(resetn), .req(stop_req), .pulse(stop_pulse));
    mic1_req_edge u_step_edge (.clk(clk), .resetn(resetn), .req(step_req), .pulse(step_pulse));

    exec_state_t      state_q, state_d;
    logic             first_q, first_d;
    logic [SC_W-1:0]  step_cyc_q, step_cyc_d;
    logic             step_done_q, step_done_d;
    logic             step_timeout_q, step_timeout_d;
    logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [15:0]      instr_cnt_q, instr_cnt_d;

    logic ce;
    logic is_main1;

    always_comb begin
        state_d        = state_q;
        first_d        = first_q;
        step_cyc_d     = step_cyc_q;
        step_done_d    = 1'b0;
        step_timeout_d = step_timeout_q;
        is_main1       = (mpc == MAIN1_ADDR);

        unique case (state_q)
            ST_RUN, ST_STEP_MICRO: ce = 1'b1;
            ST_STEP_INSTR:         ce = first_q | ~is_main1;
            default:               ce = 1'b0;
        endcase

        cycle_cnt_d = cycle_cnt_q + CYC_W'(ce);
        instr_cnt_d = instr_cnt_q + 16'(ce & is_main1);

        // Halt only applies while the datapath is actually being clocked;
        // it outranks every button pulse.
        if (ce && halt) begin
            state_d = ST_HALTED;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!stop_pulse) begin
                        if (run_pulse) begin
                            state_d        = ST_RUN;
                            step_timeout_d = 1'b0;
                        end else if (step_pulse) begin
                            step_timeout_d = 1'b0;
                            if (step_mode) begin
                                state_d    = ST_STEP_INSTR;
                                first_d    = 1'b1;
                                step_cyc_d = '0;
                            end else begin
                                state_d = ST_STEP_MICRO;
                            end
                        end
                    end
                end
                ST_RUN: begin
                    if (stop_pulse) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STEP_MICRO: begin
                    if (stop_pulse) begin
                        state_d = ST_IDLE;
                    end else if (run_pulse) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d     = ST_IDLE;
                        step_done_d = 1'b1;
                    end
                end
                ST_STEP_INSTR: begin
                    if (stop_pulse) begin
                        state_d = ST_IDLE;
                    end else if (run_pulse) begin
                        state_d = ST_RUN;
                    end else if (!ce) begin
                        // Back at Main1 after at least one executed cycle.
                        state_d     = ST_IDLE;
                        step_done_d = 1'b1;
                    end else begin
                        first_d    = 1'b0;
                        step_cyc_d = step_cyc_q + SC_W'(1);
                        if (step_cyc_d == SC_W'(STEP_MAX)) begin
                            state_d        = ST_IDLE;
                            step_done_d    = 1'b1;
                            step_timeout_d = 1'b1;
                        end
                    end
                end
                ST_HALTED: begin
                    state_d = ST_HALTED;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q        <= ST_IDLE;
            first_q        <= 1'b0;
            step_cyc_q     <= '0;
            step_done_q    <= 1'b0;
            step_timeout_q <= 1'b0;
            cycle_cnt_q    <= '0;
            instr_cnt_q    <= '0;
        end else begin
            state_q        <= state_d;
            first_q        <= first_d;
            step_cyc_q     <= step_cyc_d;
            step_done_q    <= step_done_d;
            step_timeout_q <= step_timeout_d;
            cycle_cnt_q    <= cycle_cnt_d;
            instr_cnt_q    <= instr_cnt_d;
        end
    end

    assign mic1_ce      = ce;
    assign running      = (state_q == ST_RUN);
    assign idle         = (state_q == ST_IDLE);
    assign halted       = (state_q == ST_HALTED);
    assign step_done    = step_done_q;
    assign step_timeout = step_timeout_q;
    assign cycle_cnt    = cycle_cnt_q;
    assign instr_cnt    = instr_cnt_q;
    assign led_run_step = instr_cnt_q[3:0];

endmodule
